// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature position/velocity block.
// Holds width defaults, the FSM state type and the velocity clamp.
package quad_pkg;

  localparam int POS_W_DEF = 32;
  localparam int VEL_W_DEF = 16;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  // Clamp a signed value to w bits; hit reports that clamping happened.
  function automatic logic signed [63:0] sat_vel(
    input  logic signed [63:0] d,
    input  int                 w,
    output logic               hit
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    hit = 1'b1;
    if (d > hi) begin
      sat_vel = hi;
    end else if (d < lo) begin
      sat_vel = lo;
    end else begin
      sat_vel = d;
      hit     = 1'b0;
    end
  endfunction

endpackage

// File: rtl/quad_pos_vel_if.sv
// Decoder-count in, position/velocity out.
// master drives count_in/zero_req; slave is the block itself.
interface quad_pos_vel_if
  import quad_pkg::*;
#(
  parameter int POS_W = POS_W_DEF,
  parameter int VEL_W = VEL_W_DEF
);

  logic [7:0]              count_in;
  logic                    zero_req;
  logic signed [POS_W-1:0] position;
  logic signed [VEL_W-1:0] velocity;
  logic                    vel_valid;
  logic                    overflow;

  modport master (
    output count_in, zero_req,
    input  position, velocity,
    input  vel_valid, overflow
  );

  modport slave (
    input  count_in, zero_req,
    output position, velocity,
    output vel_valid, overflow
  );

endinterface

// File: rtl/quad_window_timer.sv
// Velocity sample window timer.
// Counts 0..PERIOD_CYCLES-1 while run; tick marks the last count.
module quad_window_timer #(
  parameter int PERIOD_CYCLES = 12000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int TW = $clog2(PERIOD_CYCLES);

  logic [TW-1:0] cnt;

  assign tick = run && (cnt == TW'(PERIOD_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quad_pos_vel.sv
// Unwraps the 8-bit decoder count into an absolute position
// and measures saturating velocity over a fixed window.
module quad_pos_vel
  import quad_pkg::*;
#(
  parameter int POS_W         = POS_W_DEF,
  parameter int VEL_W         = VEL_W_DEF,
  parameter int PERIOD_CYCLES = 12000
) (
  input logic            clk,
  input logic            rst_n,
  quad_pos_vel_if.slave  bus
);

  state_t state;
  state_t state_nx;
  logic   run;

  logic [7:0]              count_prev;
  logic signed [7:0]       delta;
  logic signed [POS_W-1:0] pos_next;
  logic signed [POS_W-1:0] pos_ref;
  logic signed [POS_W:0]   diff;
  logic signed [63:0]      diff_x;
  logic signed [63:0]      vel_sat;
  logic                    clamp;
  logic                    tick;
  logic                    zero;
  logic                    win_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      INIT:    state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = INIT;
    endcase
  end

  always_comb begin
    run = 1'b0;
    unique case (state)
      RUN:     run = 1'b1;
      default: run = 1'b0;
    endcase
  end

  // Signed mod-256 difference handles the 255<->0 wrap for free.
  assign delta    = signed'(bus.count_in - count_prev);
  assign pos_next = bus.position
                  + {{(POS_W-8){delta[7]}}, delta};
  assign diff     = {pos_next[POS_W-1], pos_next}
                  - {pos_ref[POS_W-1], pos_ref};
  assign diff_x   = {{(63-POS_W){diff[POS_W]}}, diff};
  assign zero     = run & bus.zero_req;
  assign win_end  = tick & ~bus.zero_req;

  always_comb begin
    vel_sat = sat_vel(diff_x, VEL_W, clamp);
  end

  quad_window_timer #(
    .PERIOD_CYCLES (PERIOD_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .restart (zero),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_prev    <= '0;
      pos_ref       <= '0;
      bus.position  <= '0;
      bus.velocity  <= '0;
      bus.vel_valid <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      count_prev    <= bus.count_in;
      bus.vel_valid <= 1'b0;
      if (zero) begin
        bus.position <= '0;
        pos_ref      <= '0;
        bus.overflow <= 1'b0;
      end else if (run) begin
        bus.position <= pos_next;
        if (win_end) begin
          bus.velocity  <= vel_sat[VEL_W-1:0];
          bus.overflow  <= bus.overflow | clamp;
          pos_ref       <= pos_next;
          bus.vel_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_pos_vel.sv
// Bench for quad_pos_vel: two instances (P=10/W=16 and P=20/W=4)
// share stimulus and are checked against an arithmetic model.
module tb_quad_pos_vel;
  import quad_pkg::*;

  typedef struct {
    logic [7:0] c;
    logic       z;
    longint     pos;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  quad_pos_vel_if #(.POS_W(32), .VEL_W(16)) qa ();
  quad_pos_vel_if #(.POS_W(32), .VEL_W(4))  qb ();

  quad_pos_vel #(
    .POS_W(32), .VEL_W(16), .PERIOD_CYCLES(10)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(qa)
  );

  quad_pos_vel #(
    .POS_W(32), .VEL_W(4), .PERIOD_CYCLES(20)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(qb)
  );

  always #5 clk = ~clk;

  // Reference model state
  int     per [2] = '{10, 20};
  int     vw  [2] = '{16, 4};
  bit     m_init;
  int     m_prev;
  longint m_pos;
  longint m_ref [2];
  int     m_age [2];
  longint m_vel [2];
  bit     m_val [2];
  bit     m_ovf [2];

  function automatic longint w32(longint x);
    int t;
    t = int'(x);
    return longint'(t);
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1;
    m_prev = 0;
    m_pos  = 0;
    for (int k = 0; k < 2; k++) begin
      m_ref[k] = 0; m_age[k] = 0; m_vel[k] = 0;
      m_val[k] = 1'b0; m_ovf[k] = 1'b0;
    end
  endtask

  task automatic model_edge(int c, bit z);
    int     d;
    longint df, hi, lo, v;
    for (int k = 0; k < 2; k++) m_val[k] = 1'b0;
    if (m_init) begin
      m_prev = c;
      m_init = 1'b0;
      return;
    end
    d = (c - m_prev + 256) % 256;
    if (d > 127) d -= 256;
    m_prev = c;
    if (z) begin
      m_pos = 0;
      for (int k = 0; k < 2; k++) begin
        m_ref[k] = 0; m_age[k] = 0; m_ovf[k] = 1'b0;
      end
      return;
    end
    m_pos = w32(m_pos + d);
    for (int k = 0; k < 2; k++) begin
      m_age[k]++;
      if (m_age[k] == per[k]) begin
        df = m_pos - m_ref[k];
        hi = (longint'(1) <<< (vw[k] - 1)) - 1;
        lo = -(longint'(1) <<< (vw[k] - 1));
        v  = (df > hi) ? hi : (df < lo) ? lo : df;
        m_ovf[k] = m_ovf[k] | (v != df);
        m_vel[k] = v;
        m_ref[k] = m_pos;
        m_age[k] = 0;
        m_val[k] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("pos_a", longint'(qa.position), m_pos);
    chk("pos_b", longint'(qb.position), m_pos);
    chk("vel_a", longint'(qa.velocity), m_vel[0]);
    chk("vel_b", longint'(qb.velocity), m_vel[1]);
    chk("valid_a", longint'(qa.vel_valid), longint'(m_val[0]));
    chk("valid_b", longint'(qb.vel_valid), longint'(m_val[1]));
    chk("ovf_a", longint'(qa.overflow), longint'(m_ovf[0]));
    chk("ovf_b", longint'(qb.overflow), longint'(m_ovf[1]));
  endtask

  task automatic drive(logic [7:0] c, logic z);
    qa.count_in = c; qb.count_in = c;
    qa.zero_req = z; qb.zero_req = z;
    @(posedge clk);
    #1;
    model_edge(int'(c), z);
    check_all();
  endtask

  task automatic do_reset(logic [7:0] c);
    qa.count_in = c; qb.count_in = c;
    qa.zero_req = 1'b0; qb.zero_req = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_pos_a", longint'(qa.position), 0);
    chk("rst_vel_a", longint'(qa.velocity), 0);
    chk("rst_val_a", longint'(qa.vel_valid), 0);
    chk("rst_ovf_b", longint'(qb.overflow), 0);
    chk("rst_pos_b", longint'(qb.position), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t tbl1[$];
  vec_t tbl2[$];

  initial begin
    logic [7:0] c;
    int         v;
    int         p;
    int         n;
    bit         found;

    // Vector tables: expected positions from plain arithmetic
    tbl1.push_back('{8'd200, 1'b0, 0});
    tbl1.push_back('{8'd200, 1'b0, 0});
    for (int i = 1; i <= 5; i++)
      tbl1.push_back('{8'(200 + i), 1'b0, longint'(i)});
    v = 250; p = 0;
    tbl2.push_back('{8'(v), 1'b0, 0});
    for (int i = 0; i < 11; i++) begin
      v = (v + 1) % 256; p++;
      tbl2.push_back('{8'(v), 1'b0, longint'(p)});
    end
    for (int i = 0; i < 11; i++) begin
      v = (v + 255) % 256; p--;
      tbl2.push_back('{8'(v), 1'b0, longint'(p)});
    end

    model_reset();
    do_reset(8'd200);
    foreach (tbl1[i]) begin
      drive(tbl1[i].c, tbl1[i].z);
      chk("tbl1_pos", longint'(qa.position), tbl1[i].pos);
    end

    do_reset(8'd250);
    foreach (tbl2[i]) begin
      drive(tbl2[i].c, tbl2[i].z);
      chk("tbl2_pos", longint'(qa.position), tbl2[i].pos);
    end

    // +1 per clock: A sees 10, B saturates at 7
    do_reset(8'd17);
    c = 8'd17;
    drive(c, 1'b0);
    for (int i = 0; i < 45; i++) begin
      c = c + 8'd1;
      drive(c, 1'b0);
    end
    chk("up_vel_a", longint'(qa.velocity), 10);
    chk("up_vel_b", longint'(qb.velocity), 7);
    chk("up_ovf_b", longint'(qb.overflow), 1);
    c = c + 8'd1;
    drive(c, 1'b1);
    chk("zero_ovf_b", longint'(qb.overflow), 0);
    chk("zero_pos", longint'(qa.position), 0);

    // -1 every other clock: A sees -5, B clamps to -8
    do_reset(8'd3);
    c = 8'd3;
    drive(c, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 1) c = c - 8'd1;
      drive(c, 1'b0);
    end
    chk("dn_vel_a", longint'(qa.velocity), -5);
    chk("dn_vel_b", longint'(qb.velocity), -8);

    // zero_req landing on A's window end
    do_reset(8'd0);
    c = 8'd0;
    drive(c, 1'b0);
    for (int i = 0; i < 9; i++) begin
      c = c + 8'd1;
      drive(c, 1'b0);
    end
    c = c + 8'd1;
    drive(c, 1'b1);
    chk("zwin_valid", longint'(qa.vel_valid), 0);
    n = 0;
    found = 1'b0;
    while (n < 30 && !found) begin
      c = c + 8'd1;
      drive(c, 1'b0);
      n++;
      if (qa.vel_valid) found = 1'b1;
    end
    chk("zwin_lat", longint'(n), 10);
    chk("zwin_vel", longint'(qa.velocity), 10);

    // Mid-window async reset while counting
    for (int i = 0; i < 4; i++) begin
      c = c + 8'd1;
      drive(c, 1'b0);
    end
    do_reset(c);
    drive(c, 1'b0);
    chk("rst_init_pos", longint'(qa.position), 0);

    // Random walk with occasional zero and reset
    for (int i = 0; i < 600; i++) begin
      c = c + 8'($urandom_range(0, 2)) - 8'd1;
      if ($urandom_range(0, 199) == 0)
        do_reset(c);
      else
        drive(c, $urandom_range(0, 39) == 0);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
